// File: rtl/frame_buf_rd_fetch_if.sv
// ---------------------------------------------------------------------------
// frame_buf_rd_fetch_if
//   Bundles the two buses of the frame-buffer read-fetch stage:
//   - Avalon read side: avl_read_req / avl_ready / avl_rdata / avl_rdata_valid
//     from the frame buffer and memory, plus the active-low rd_en throttle
//     going back to the frame buffer.
//   - Pixel stream side: pix_data / pix_valid / pix_ready with the
//     pix_sof / pix_eol frame markers.
//   Modports:
//     master - the fetch stage (drives rd_en and the pixel stream)
//     slave  - the surroundings (frame buffer, memory, pixel consumer)
// ---------------------------------------------------------------------------
interface frame_buf_rd_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  avl_read_req;
  logic                  avl_ready;
  logic [DATA_WIDTH-1:0] avl_rdata;
  logic                  avl_rdata_valid;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;

  modport master (
    input  avl_read_req,
    input  avl_ready,
    input  avl_rdata,
    input  avl_rdata_valid,
    input  pix_ready,
    output rd_en,
    output pix_data,
    output pix_valid,
    output pix_sof,
    output pix_eol
  );

  modport slave (
    output avl_read_req,
    output avl_ready,
    output avl_rdata,
    output avl_rdata_valid,
    output pix_ready,
    input  rd_en,
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    input  pix_eol
  );
endinterface

// File: rtl/frame_buf_rd_fetch.sv
// ---------------------------------------------------------------------------
// frame_buf_rd_fetch
//   Read-side fetch stage of the frame buffer. Throttles the frame buffer's
//   active-low read enable with credit-based flow control, captures Avalon
//   read-return data into a small first-word-fall-through FIFO and presents
//   it as a valid/ready pixel stream with start-of-frame / end-of-line
//   markers. Overflow and underrun are reported as sticky error flags.
//
// Ports:
//   rd_clk     in   single clock, rising edge
//   reset      in   synchronous, active-high
//   stream_en  in   high = fetch frames continuously
//   clr_err    in   clears the sticky error flags
//   overflow   out  sticky: return data arrived while the FIFO was full
//   underrun   out  sticky: consumer starved mid-frame while fetching
//   bus        master modport of frame_buf_rd_fetch_if (Avalon read side,
//              rd_en throttle, pixel stream)
// ---------------------------------------------------------------------------
module frame_buf_rd_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int SLACK      = 2,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic                 stream_en,
  input  logic                 clr_err,
  output logic                 overflow,
  output logic                 underrun,
  frame_buf_rd_fetch_if.master bus
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [FIFO_AW+1:0] CREDIT_LIMIT = (FIFO_AW+2)'(FIFO_DEPTH - SLACK);
  localparam logic [FIFO_AW:0]   FULL_COUNT   = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE      = (FIFO_AW+1)'(1);
  localparam logic [XW-1:0]      X_LAST       = XW'(H_RES - 1);
  localparam logic [YW-1:0]      Y_LAST       = YW'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   rd_en_reg, rd_en_next;

  // Return FIFO storage. At this depth it maps to distributed RAM, so the
  // head word is read asynchronously to get fall-through timing.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]      count_reg, count_next;
  logic [FIFO_AW:0]      outstanding_reg, outstanding_next;

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;

  logic overflow_reg, underrun_reg;

  logic                accept;
  logic                rvalid;
  logic                fifo_full;
  logic                fifo_valid;
  logic                pop;
  logic                push;
  logic                overflow_set;
  logic                underrun_set;
  logic [FIFO_AW+1:0]  credit_sum;
  logic                credit_ok;
  logic                mid_frame;

  assign accept     = bus.avl_read_req & bus.avl_ready;
  assign rvalid     = bus.avl_rdata_valid;
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_valid = (count_reg != '0);
  assign pop        = fifo_valid & bus.pix_ready;

  // Returns seen in IDLE belong to requests cancelled by a reset; drop them
  // silently. A full FIFO still accepts a word when the head leaves the
  // same cycle.
  assign push         = rvalid & (state_reg != IDLE) & (~fifo_full | pop);
  assign overflow_set = rvalid & (state_reg != IDLE) & fifo_full & ~pop;

  // Words already buffered plus words still in flight must leave SLACK
  // entries free for requests the frame buffer issues before it sees rd_en.
  assign credit_sum = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign credit_ok  = (credit_sum < CREDIT_LIMIT);

  assign mid_frame    = (x_reg != '0) | (y_reg != '0);
  assign underrun_set = (state_reg == FETCH) & bus.pix_ready & ~fifo_valid & mid_frame;

  // Outstanding credits: increment on accepted request, decrement on return,
  // never below zero (stray returns are ignored).
  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !rvalid) begin
      outstanding_next = outstanding_reg + CNT_ONE;
    end else if (!accept && rvalid && (outstanding_reg != '0)) begin
      outstanding_next = outstanding_reg - CNT_ONE;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // FSM next-state and registered rd_en value
  always_comb begin
    state_next = state_reg;
    rd_en_next = 1'b1;
    case (state_reg)
      IDLE: begin
        if (stream_en) state_next = FETCH;
      end
      FETCH: begin
        if (!stream_en) begin
          state_next = DRAIN;
        end else begin
          rd_en_next = ~credit_ok;
        end
      end
      DRAIN: begin
        // Re-enabling during drain only takes effect once back in IDLE.
        if (outstanding_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rd_en_reg       <= 1'b1;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      overflow_reg    <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rd_en_reg       <= rd_en_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);

      // Frame position follows consumed pixels only, so pausing the
      // stream keeps it aligned with the frame buffer's address.
      if (pop) begin
        if (x_reg == X_LAST) begin
          x_reg <= '0;
          y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
        end else begin
          x_reg <= x_reg + XW'(1);
        end
      end

      // Set has priority over clear.
      overflow_reg <= overflow_set | (overflow_reg & ~clr_err);
      underrun_reg <= underrun_set | (underrun_reg & ~clr_err);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr_reg] <= bus.avl_rdata;
  end

  assign bus.rd_en     = rd_en_reg;
  assign bus.pix_data  = mem[rd_ptr_reg];
  assign bus.pix_valid = fifo_valid;
  assign bus.pix_sof   = fifo_valid & (x_reg == '0) & (y_reg == '0);
  assign bus.pix_eol   = fifo_valid & (x_reg == X_LAST);

  assign overflow = overflow_reg;
  assign underrun = underrun_reg;

endmodule
